// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter: NUM_REQ AXI-Stream sources onto one sink, grant held to tlast or MAX_BEATS.
// Zero-cycle data path (combinational mux); 1 arbitration cycle between grants; sink tready routed only to the granted source.
module axis_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst,
    input  logic [NUM_REQ-1:0]            s_axis_tvalid,
    output logic [NUM_REQ-1:0]            s_axis_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]            s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          split_pulse
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            xfer;
    logic            cap;
    logic            beat;
    logic            pick_vld;
    logic [IW-1:0]   pick_id;
    logic [IW:0]     idx;
    logic [IW-1:0]   idx_w;

    // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = '0;
        idx_w    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(NUM_REQ)) begin
                idx = idx - (IW+1)'(NUM_REQ);
            end
            idx_w = idx[IW-1:0];
            if (s_axis_tvalid[idx_w]) begin
                pick_vld = 1'b1;
                pick_id  = idx_w;
            end
        end
    end

    assign xfer          = (state_q == XFER);
    assign cap           = (beat_cnt_q == CW'(MAX_BEATS - 1));
    assign m_axis_tvalid = xfer & s_axis_tvalid[grant_q];
    assign m_axis_tdata  = xfer ? s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_axis_tlast  = xfer & (s_axis_tlast[grant_q] | cap);
    assign beat          = m_axis_tvalid & m_axis_tready;
    assign split_pulse   = beat & cap & ~s_axis_tlast[grant_q];
    assign grant_valid   = xfer;
    assign grant_id      = grant_q;

    always_comb begin
        s_axis_tready = '0;
        if (xfer) begin
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d    = XFER;
                    grant_d    = pick_id;
                    beat_cnt_d = '0;
                end
            end
            XFER: begin
                if (beat) begin
                    if (m_axis_tlast) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-requester scoreboards plus grant order, backpressure, split and reset checks.
module tb_axis_rr_arbiter;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    tvalid, tlast, s_tready;
    logic [N*DW-1:0] tdata;
    logic            m_valid, mrdy, m_last, gv, split;
    logic [DW-1:0]   m_data;
    logic [1:0]      gid;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t        src_q[N][$];
    beat_t        exp_q[N][$];
    int           vectors = 0;
    int           errs    = 0;
    int           mcnt    = 0;
    logic [N-1:0] hs;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .axis_clk      (clk),
        .axis_rst      (rst),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (tdata),
        .s_axis_tlast  (tlast),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (mrdy),
        .m_axis_tdata  (m_data),
        .m_axis_tlast  (m_last),
        .grant_valid   (gv),
        .grant_id      (gid),
        .split_pulse   (split)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.last = l;
        b.data = d;
        src_q[i].push_back(b);
        exp_q[i].push_back(b);
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) begin
                tvalid[i]           = 1'b1;
                tdata[i*DW +: DW]   = src_q[i][0].data;
                tlast[i]            = src_q[i][0].last;
            end else begin
                tvalid[i]           = 1'b0;
                tdata[i*DW +: DW]   = '0;
                tlast[i]            = 1'b0;
            end
        end
    endtask

    // Sample at the falling edge; every sink beat is scored against the granted requester's queue.
    task automatic sample();
        beat_t b;
        int    g;
        logic  el;
        @(negedge clk);
        hs = tvalid & s_tready;
        chk("tready_onehot", 64'($countones(s_tready) <= 1), 64'(1));
        if (m_valid === 1'b1 && mrdy === 1'b1) begin
            g = int'(gid);
            chk("beat_grant_valid", 64'(gv), 64'(1));
            chk("beat_has_expected", 64'(exp_q[g].size() != 0), 64'(1));
            if (exp_q[g].size() != 0) begin
                b  = exp_q[g].pop_front();
                el = b.last | (mcnt == MAXB - 1);
                chk("beat_data", 64'(m_data), 64'(b.data));
                chk("beat_tlast", 64'(m_last), 64'(el));
                chk("beat_split", 64'(split), 64'(el & ~b.last));
                mcnt = el ? 0 : mcnt + 1;
            end
        end else begin
            chk("no_beat_split", 64'(split), 64'(0));
        end
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        hs = '0;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            sample();
            done = srcs_empty() && (gv === 1'b0);
            advance();
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
        chk({tag, "_m_last"}, 64'(m_last), 64'(0));
        chk({tag, "_m_data"}, 64'(m_data), 64'(0));
        chk({tag, "_s_tready"}, 64'(s_tready), 64'(0));
        chk({tag, "_grant_valid"}, 64'(gv), 64'(0));
        chk({tag, "_grant_id"}, 64'(gid), 64'(0));
        chk({tag, "_split"}, 64'(split), 64'(0));
    endtask

    initial begin
        hs   = '0;
        rst  = 1'b1;
        mrdy = 1'b1;

        // Reset held with every requester valid
        for (int i = 0; i < N; i++) push(i, 32'h10 + i, 1'b1);
        drive();
        sample(); chk_zero("rst_a"); advance();
        sample(); chk_zero("rst_b"); advance();
        rst = 1'b0;
        sample(); chk("rel_idle_gv", 64'(gv), 64'(0)); advance();
        sample();
        chk("rel_gv", 64'(gv), 64'(1));
        chk("rel_gid", 64'(gid), 64'(0));
        advance();
        drain("drain_t1", 40);

        // Single 3-beat packet from req2
        push(2, 32'hA0, 1'b0); push(2, 32'hA1, 1'b0); push(2, 32'hA2, 1'b1);
        drive();
        sample(); chk("t2_req_idle", 64'(gv), 64'(0)); advance();
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("t2_gv", 64'(gv), 64'(1));
            chk("t2_gid", 64'(gid), 64'(2));
            chk("t2_valid", 64'(m_valid), 64'(1));
            chk("t2_last", 64'(m_last), 64'(k == 2));
            advance();
        end
        sample();
        chk("t2_back_idle", 64'(gv), 64'(0));
        push(0, 32'hB0, 1'b1); push(3, 32'hB3, 1'b1);
        drive();
        advance();
        sample(); chk("t2_rr_ptr3", 64'(gid), 64'(3)); advance();
        drain("drain_t2", 40);

        // Fresh reset, then all four requesters with back-to-back 1-beat packets
        rst = 1'b1; advance(); rst = 1'b0; mcnt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push(i, 32'h300 + r*16 + i, 1'b1);
        end
        drive();
        for (int k = 0; k < 16; k++) begin
            sample();
            if (k % 2 == 0) begin
                chk("t3_gap", 64'(gv), 64'(0));
            end else begin
                chk("t3_gv", 64'(gv), 64'(1));
                chk("t3_order", 64'(gid), 64'((k / 2) % N));
            end
            advance();
        end
        drain("drain_t3", 10);

        // req1 4-beat packet under toggling sink ready
        for (int b = 0; b < 4; b++) push(1, 32'h40 + b, b == 3);
        drive();
        sample(); advance();
        for (int k = 0; k < 7; k++) begin
            mrdy = (k % 2 == 0);
            sample();
            chk("t4_gv", 64'(gv), 64'(1));
            chk("t4_tready", 64'(s_tready), 64'(mrdy ? 4'b0010 : 4'b0000));
            advance();
        end
        mrdy = 1'b1;
        drain("drain_t4", 20);
        chk("t4_all_beats", 64'(exp_q[1].size()), 64'(0));

        // req0 6-beat packet split at MAXB
        for (int b = 0; b < 6; b++) push(0, 32'h50 + b, b == 5);
        drive();
        sample(); advance();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("t5_last", 64'(m_last), 64'(k == 3));
            chk("t5_split", 64'(split), 64'(k == 3));
            advance();
        end
        sample(); chk("t5_rearb_idle", 64'(gv), 64'(0)); advance();
        sample();
        chk("t5_regrant", 64'(gv), 64'(1));
        chk("t5_regrant_id", 64'(gid), 64'(0));
        advance();
        drain("drain_t5", 20);

        // Reset in the middle of a req3 packet
        for (int b = 0; b < 5; b++) push(3, 32'h60 + b, b == 4);
        drive();
        sample(); advance();
        sample(); chk("t6_gid", 64'(gid), 64'(3)); advance();
        sample(); advance();
        mrdy = 1'b0;
        rst  = 1'b1;
        sample(); advance();
        mcnt = 0;
        sample(); chk_zero("t6_rst");
        src_q[3].delete();
        exp_q[3].delete();
        rst  = 1'b0;
        mrdy = 1'b1;
        push(1, 32'h71, 1'b1); push(3, 32'h73, 1'b1);
        drive();
        advance();
        sample(); chk("t6_first_gid", 64'(gid), 64'(1)); chk("t6_first_gv", 64'(gv), 64'(1)); advance();
        sample(); advance();
        sample(); chk("t6_second_gid", 64'(gid), 64'(3)); advance();
        drain("drain_t6", 20);

        for (int i = 0; i < N; i++) chk($sformatf("leftover_exp%0d", i), 64'(exp_q[i].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
